// File: rtl/hls_df_ctrl_pkg.sv
// Shared definitions for the hls_xfft2real dataflow run controller.
//   run_state_e        : controller state encoding (IDLE/RUN/DRAIN/HALT)
//   AXIS_INFO_W        : width of the deadlock monitor's per-AXIS-port code
//   DL_THRESH_DEFAULT  : default consecutive-block cycle count declaring deadlock
package hls_df_ctrl_pkg;

    localparam int unsigned AXIS_INFO_W       = 4;
    localparam int unsigned DL_THRESH_DEFAULT = 1024;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StHalt
    } run_state_e;

    // Busy covers every state in which the region is being driven.
    function automatic logic state_is_busy(run_state_e s);
        return (s == StRun) || (s == StDrain);
    endfunction

endpackage

// File: rtl/hls_df_dl_timer.sv
// Deadlock timer: counts consecutive enabled cycles with block_i high and
// raises hit_o in the cycle whose sampling edge is the THRESH-th consecutive one.
// Ports:
//   clock   : rising-edge clock
//   reset   : asynchronous active-high reset
//   en_i    : counting enabled (controller busy); low clears the count
//   block_i : deadlock-monitor block flag; low clears the count
//   hit_o   : combinational hit, consumed by the controller on the same edge
module hls_df_dl_timer
    import hls_df_ctrl_pkg::*;
#(
    parameter int unsigned THRESH = DL_THRESH_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic en_i,
    input  logic block_i,
    output logic hit_o
);

    // Count only needs to reach THRESH-1; the THRESH-th cycle is the hit itself.
    localparam int unsigned CntW = (THRESH > 1) ? $clog2(THRESH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(THRESH - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            hit;

    always_comb begin
        hit   = en_i && block_i && (cnt_q == CntLast);
        cnt_d = '0;
        if (en_i && block_i && !hit) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_o = hit;

endmodule

// File: rtl/hls_df_run_ctrl.sv
// Run controller for the hls_xfft2real dataflow region. Drives the region's
// ap_ctrl_chain handshake for a batch of frames, drains in-flight frames on
// completion or abort, and halts with a captured diagnosis on deadlock.
// Optional build macro: HLS_DF_CTRL_PERF_EN adds perf_busy_cyc/perf_block_cyc.
// Ports:
//   clock, reset                 : clock, asynchronous active-high reset
//   cmd_run/cmd_abort/cmd_clear  : command pulses (start batch, stop issuing, leave HALT)
//   cfg_frames                   : frames per batch, 0 = continuous
//   dut_ap_*                     : region block-level control port
//   mon_block/mon_axis_block_info: AXIS deadlock monitor outputs
//   busy, batch_done, frames_done, deadlock, dl_info : status (all registered)
//   perf_busy_cyc, perf_block_cyc: saturating cycle counters (perf build only)
module hls_df_run_ctrl
    import hls_df_ctrl_pkg::*;
#(
    parameter int unsigned DL_THRESH = DL_THRESH_DEFAULT,
    parameter int unsigned FRM_W     = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cmd_run,
    input  logic                   cmd_abort,
    input  logic                   cmd_clear,
    input  logic [FRM_W-1:0]       cfg_frames,
    output logic                   dut_ap_start,
    input  logic                   dut_ap_ready,
    input  logic                   dut_ap_done,
    input  logic                   dut_ap_idle,
    output logic                   dut_ap_continue,
    input  logic                   mon_block,
    input  logic [AXIS_INFO_W-1:0] mon_axis_block_info,
`ifdef HLS_DF_CTRL_PERF_EN
    output logic [31:0]            perf_busy_cyc,
    output logic [31:0]            perf_block_cyc,
`endif
    output logic                   busy,
    output logic                   batch_done,
    output logic [FRM_W-1:0]       frames_done,
    output logic                   deadlock,
    output logic [AXIS_INFO_W-1:0] dl_info
);

    run_state_e             state_q, state_d;
    logic [FRM_W-1:0]       target_q, target_d;
    logic [FRM_W-1:0]       issued_q, issued_d;
    logic [FRM_W-1:0]       frames_q, frames_d;
    logic                   abort_pend_q, abort_pend_d;
    logic                   start_q, start_d;
    logic                   cont_q, cont_d;
    logic                   busy_q, busy_d;
    logic                   batch_done_q, batch_done_d;
    logic                   deadlock_q, deadlock_d;
    logic [AXIS_INFO_W-1:0] dl_info_q, dl_info_d;

    logic             hs_issue;
    logic             hs_done;
    logic             abort_eff;
    logic [FRM_W-1:0] issued_inc;
    logic             dl_hit;

    hls_df_dl_timer #(
        .THRESH (DL_THRESH)
    ) u_dl_timer (
        .clock   (clock),
        .reset   (reset),
        .en_i    (state_is_busy(state_q)),
        .block_i (mon_block),
        .hit_o   (dl_hit)
    );

    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        issued_d     = issued_q;
        frames_d     = frames_q;
        abort_pend_d = abort_pend_q;
        start_d      = 1'b0;
        batch_done_d = 1'b0;
        deadlock_d   = deadlock_q;
        dl_info_d    = dl_info_q;

        hs_issue   = start_q & dut_ap_ready;
        hs_done    = cont_q & dut_ap_done;
        abort_eff  = abort_pend_q | cmd_abort;
        issued_inc = issued_q + FRM_W'(1);

        unique case (state_q)
            StIdle: begin
                if (cmd_run) begin
                    state_d      = StRun;
                    target_d     = cfg_frames;
                    issued_d     = '0;
                    frames_d     = '0;
                    abort_pend_d = 1'b0;
                end
            end
            StRun: begin
                if (hs_issue) begin
                    issued_d = issued_inc;
                end
                if (hs_done) begin
                    frames_d = frames_q + FRM_W'(1);
                end
                if (dl_hit) begin
                    state_d      = StHalt;
                    deadlock_d   = 1'b1;
                    dl_info_d    = mon_axis_block_info;
                    abort_pend_d = 1'b0;
                end else if (abort_eff && (!start_q || hs_issue)) begin
                    // A raised start is never withdrawn; abort waits for its ready.
                    state_d      = StDrain;
                    target_d     = issued_d;
                    abort_pend_d = 1'b0;
                end else if (hs_issue && (target_q != '0) && (issued_inc == target_q)) begin
                    state_d = StDrain;
                end else begin
                    // Staying in RUN: either holding an outstanding start or issuing the next.
                    abort_pend_d = abort_eff;
                    start_d      = 1'b1;
                end
            end
            StDrain: begin
                if (hs_done) begin
                    frames_d = frames_q + FRM_W'(1);
                end
                if (dl_hit) begin
                    state_d    = StHalt;
                    deadlock_d = 1'b1;
                    dl_info_d  = mon_axis_block_info;
                end else if ((frames_q == issued_q) && dut_ap_idle) begin
                    state_d      = StIdle;
                    batch_done_d = 1'b1;
                end
            end
            StHalt: begin
                if (cmd_clear) begin
                    state_d    = StIdle;
                    deadlock_d = 1'b0;
                    dl_info_d  = '0;
                end
            end
        endcase

        busy_d = state_is_busy(state_d);
        cont_d = busy_d;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            target_q     <= '0;
            issued_q     <= '0;
            frames_q     <= '0;
            abort_pend_q <= 1'b0;
            start_q      <= 1'b0;
            cont_q       <= 1'b0;
            busy_q       <= 1'b0;
            batch_done_q <= 1'b0;
            deadlock_q   <= 1'b0;
            dl_info_q    <= '0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            issued_q     <= issued_d;
            frames_q     <= frames_d;
            abort_pend_q <= abort_pend_d;
            start_q      <= start_d;
            cont_q       <= cont_d;
            busy_q       <= busy_d;
            batch_done_q <= batch_done_d;
            deadlock_q   <= deadlock_d;
            dl_info_q    <= dl_info_d;
        end
    end

    assign dut_ap_start    = start_q;
    assign dut_ap_continue = cont_q;
    assign busy            = busy_q;
    assign batch_done      = batch_done_q;
    assign frames_done     = frames_q;
    assign deadlock        = deadlock_q;
    assign dl_info         = dl_info_q;

`ifdef HLS_DF_CTRL_PERF_EN
    logic [31:0] perf_busy_q, perf_busy_d;
    logic [31:0] perf_block_q, perf_block_d;

    always_comb begin
        perf_busy_d  = perf_busy_q;
        perf_block_d = perf_block_q;
        if ((state_q == StIdle) && cmd_run) begin
            perf_busy_d  = '0;
            perf_block_d = '0;
        end else begin
            if (busy_q && !(&perf_busy_q)) begin
                perf_busy_d = perf_busy_q + 32'd1;
            end
            if (busy_q && mon_block && !(&perf_block_q)) begin
                perf_block_d = perf_block_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_busy_q  <= '0;
            perf_block_q <= '0;
        end else begin
            perf_busy_q  <= perf_busy_d;
            perf_block_q <= perf_block_d;
        end
    end

    assign perf_busy_cyc  = perf_busy_q;
    assign perf_block_cyc = perf_block_q;
`endif

endmodule

// File: tb/tb_hls_df_run_ctrl.sv
module tb_hls_df_run_ctrl;

    logic       clock;
    logic       reset;
    logic       cmd_run;
    logic       cmd_abort;
    logic       cmd_clear;
    logic [3:0] cfg_frames;
    logic       dut_ap_start;
    logic       dut_ap_ready;
    logic       dut_ap_done;
    logic       dut_ap_idle;
    logic       dut_ap_continue;
    logic       mon_block;
    logic [3:0] mon_axis_block_info;
    logic       busy;
    logic       batch_done;
    logic [3:0] frames_done;
    logic       deadlock;
    logic [3:0] dl_info;

    hls_df_run_ctrl #(
        .DL_THRESH (8),
        .FRM_W     (4)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .cmd_run             (cmd_run),
        .cmd_abort           (cmd_abort),
        .cmd_clear           (cmd_clear),
        .cfg_frames          (cfg_frames),
        .dut_ap_start        (dut_ap_start),
        .dut_ap_ready        (dut_ap_ready),
        .dut_ap_done         (dut_ap_done),
        .dut_ap_idle         (dut_ap_idle),
        .dut_ap_continue     (dut_ap_continue),
        .mon_block           (mon_block),
        .mon_axis_block_info (mon_axis_block_info),
        .busy                (busy),
        .batch_done          (batch_done),
        .frames_done         (frames_done),
        .deadlock            (deadlock),
        .dl_info             (dl_info)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Region model: ready after rdy_dly cycles of start, done dly cycles after each issue.
    int rdy_dly;
    int done_dly;
    int wait_cnt;
    int cyc;
    int n_hs;
    int n_cmp;
    int bd_cnt;
    int done_q[$];

    typedef struct {
        logic [3:0] cfg;
        int         rdy;
        int         dly;
        logic [3:0] exp_frames;
        int         exp_hs;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_inputs();
        dut_ap_ready = dut_ap_start && (wait_cnt >= rdy_dly);
        dut_ap_done  = (done_q.size() > 0) && (done_q[0] <= cyc);
        dut_ap_idle  = (done_q.size() == 0) && !dut_ap_start;
    endtask

    task automatic model_reset();
        done_q.delete();
        wait_cnt = 0;
        n_hs     = 0;
        n_cmp    = 0;
        bd_cnt   = 0;
        model_inputs();
    endtask

    // One clock: capture handshakes seen at the edge, then update the model 1 ns later.
    task automatic cycle();
        logic st, hs, cp;
        st = dut_ap_start;
        hs = dut_ap_start & dut_ap_ready;
        cp = dut_ap_done & dut_ap_continue;
        @(posedge clock);
        #1;
        cmd_run   = 1'b0;
        cmd_abort = 1'b0;
        cmd_clear = 1'b0;
        cyc++;
        if (hs) begin
            n_hs++;
            done_q.push_back(cyc + done_dly);
            wait_cnt = 0;
        end else if (st) begin
            wait_cnt++;
        end else begin
            wait_cnt = 0;
        end
        if (cp && done_q.size() > 0) begin
            void'(done_q.pop_front());
            n_cmp++;
        end
        if (batch_done) bd_cnt++;
        model_inputs();
    endtask

    task automatic wait_idle(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (bd_cnt > 0 && !busy) break;
            cycle();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{cfg: 4'd3, rdy: 0, dly: 20, exp_frames: 4'd3, exp_hs: 3};
        vecs[1] = '{cfg: 4'd1, rdy: 2, dly: 5,  exp_frames: 4'd1, exp_hs: 1};
        vecs[2] = '{cfg: 4'd5, rdy: 1, dly: 3,  exp_frames: 4'd5, exp_hs: 5};
        vecs[3] = '{cfg: 4'd4, rdy: 3, dly: 1,  exp_frames: 4'd4, exp_hs: 4};

        reset = 1'b1;
        cmd_run = 1'b0;
        cmd_abort = 1'b0;
        cmd_clear = 1'b0;
        cfg_frames = 4'd0;
        mon_block = 1'b0;
        mon_axis_block_info = 4'd0;
        rdy_dly = 0;
        done_dly = 1;
        cyc = 0;
        dut_ap_ready = 1'b0;
        dut_ap_done = 1'b0;
        dut_ap_idle = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_start", {31'd0, dut_ap_start}, 32'd0);
        chk("rst_cont", {31'd0, dut_ap_continue}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_frames", {28'd0, frames_done}, 32'd0);
        chk("rst_deadlock", {31'd0, deadlock}, 32'd0);
        chk("rst_dlinfo", {28'd0, dl_info}, 32'd0);
        #3 reset = 1'b0;
        model_reset();

        // Table-driven normal batches.
        for (int v = 0; v < 4; v++) begin
            bit seen_final;
            rdy_dly = vecs[v].rdy;
            done_dly = vecs[v].dly;
            model_reset();
            cfg_frames = vecs[v].cfg;
            cmd_run = 1'b1;
            cycle();
            chk($sformatf("v%0d_busy_after_run", v), {31'd0, busy}, 32'd1);
            chk($sformatf("v%0d_start_not_yet", v), {31'd0, dut_ap_start}, 32'd0);
            cycle();
            chk($sformatf("v%0d_start_raised", v), {31'd0, dut_ap_start}, 32'd1);
            seen_final = 1'b0;
            for (int i = 0; i < 300; i++) begin
                if (bd_cnt > 0 && !busy) break;
                cycle();
                if (!seen_final && n_hs == vecs[v].exp_hs) begin
                    seen_final = 1'b1;
                    chk($sformatf("v%0d_start_low_final", v), {31'd0, dut_ap_start}, 32'd0);
                end
            end
            repeat (3) cycle();
            chk($sformatf("v%0d_busy_end", v), {31'd0, busy}, 32'd0);
            chk($sformatf("v%0d_frames", v), {28'd0, frames_done}, {28'd0, vecs[v].exp_frames});
            chk($sformatf("v%0d_issues", v), n_hs, vecs[v].exp_hs);
            chk($sformatf("v%0d_batch_done_pulses", v), bd_cnt, 1);
        end

        // Abort while start is waiting for ready.
        rdy_dly = 5;
        done_dly = 4;
        model_reset();
        cfg_frames = 4'd5;
        cmd_run = 1'b1;
        cycle();
        cycle();
        cycle();
        cmd_abort = 1'b1;
        cycle();
        chk("abort_start_held", {31'd0, dut_ap_start}, 32'd1);
        for (int i = 0; i < 20 && n_hs == 0; i++) cycle();
        chk("abort_start_dropped", {31'd0, dut_ap_start}, 32'd0);
        chk("abort_draining", {31'd0, busy}, 32'd1);
        wait_idle(100);
        repeat (2) cycle();
        chk("abort_issues", n_hs, 1);
        chk("abort_frames", {28'd0, frames_done}, 32'd1);
        chk("abort_bd", bd_cnt, 1);
        chk("abort_idle", {31'd0, busy}, 32'd0);

        // Deadlock: 7 high, 1 low, 8 high.
        rdy_dly = 100;
        done_dly = 1;
        model_reset();
        cfg_frames = 4'd2;
        cmd_run = 1'b1;
        cycle();
        cycle();
        mon_block = 1'b1;
        mon_axis_block_info = 4'h3;
        for (int i = 0; i < 7; i++) begin
            cycle();
            chk($sformatf("dl_first_burst_%0d", i), {31'd0, deadlock}, 32'd0);
        end
        mon_block = 1'b0;
        cycle();
        mon_block = 1'b1;
        mon_axis_block_info = 4'hD;
        for (int i = 0; i < 7; i++) begin
            cycle();
            chk($sformatf("dl_second_burst_%0d", i), {31'd0, deadlock}, 32'd0);
        end
        cycle();
        mon_block = 1'b0;
        mon_axis_block_info = 4'h0;
        chk("dl_set", {31'd0, deadlock}, 32'd1);
        chk("dl_info", {28'd0, dl_info}, 32'hD);
        chk("dl_start_off", {31'd0, dut_ap_start}, 32'd0);
        chk("dl_cont_off", {31'd0, dut_ap_continue}, 32'd0);
        chk("dl_not_busy", {31'd0, busy}, 32'd0);
        cmd_run = 1'b1;
        cycle();
        cycle();
        chk("halt_ignores_run", {31'd0, busy}, 32'd0);
        chk("halt_dl_sticky", {31'd0, deadlock}, 32'd1);
        cmd_clear = 1'b1;
        cycle();
        chk("clear_dl", {31'd0, deadlock}, 32'd0);
        chk("clear_info", {28'd0, dl_info}, 32'd0);
        chk("halt_no_bd", bd_cnt, 0);
        rdy_dly = 0;
        cfg_frames = 4'd1;
        cmd_run = 1'b1;
        cycle();
        chk("run_after_clear", {31'd0, busy}, 32'd1);
        wait_idle(100);
        chk("run_after_clear_bd", bd_cnt, 1);

        // Deadlock and abort on the same edge.
        rdy_dly = 100;
        model_reset();
        cfg_frames = 4'd3;
        cmd_run = 1'b1;
        cycle();
        cycle();
        mon_block = 1'b1;
        mon_axis_block_info = 4'h6;
        repeat (7) cycle();
        cmd_abort = 1'b1;
        cycle();
        mon_block = 1'b0;
        chk("dlab_deadlock", {31'd0, deadlock}, 32'd1);
        chk("dlab_info", {28'd0, dl_info}, 32'h6);
        chk("dlab_busy", {31'd0, busy}, 32'd0);
        repeat (4) cycle();
        chk("dlab_no_bd", bd_cnt, 0);
        cmd_clear = 1'b1;
        cycle();
        chk("dlab_cleared", {31'd0, deadlock}, 32'd0);

        // Continuous mode wrap.
        rdy_dly = 0;
        done_dly = 2;
        model_reset();
        cfg_frames = 4'd0;
        cmd_run = 1'b1;
        cycle();
        for (int i = 0; i < 100 && n_cmp < 17; i++) cycle();
        chk("wrap_frames", {28'd0, frames_done}, 32'd1);
        chk("wrap_busy", {31'd0, busy}, 32'd1);
        repeat (5) cycle();
        chk("wrap_stays_run", {31'd0, busy}, 32'd1);
        cmd_abort = 1'b1;
        cycle();
        wait_idle(100);
        repeat (2) cycle();
        chk("wrap_abort_frames", {28'd0, frames_done}, n_hs % 16);
        chk("wrap_abort_bd", bd_cnt, 1);

        // Asynchronous reset mid-DRAIN.
        rdy_dly = 0;
        done_dly = 3;
        model_reset();
        cfg_frames = 4'd2;
        cmd_run = 1'b1;
        cycle();
        for (int i = 0; i < 30 && frames_done != 4'd1; i++) cycle();
        chk("mid_drain_busy", {31'd0, busy}, 32'd1);
        chk("mid_drain_start", {31'd0, dut_ap_start}, 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_cont", {31'd0, dut_ap_continue}, 32'd0);
        chk("arst_frames", {28'd0, frames_done}, 32'd0);
        chk("arst_bd", {31'd0, batch_done}, 32'd0);
        #2 reset = 1'b0;
        done_dly = 3;
        model_reset();
        cfg_frames = 4'd1;
        cmd_run = 1'b1;
        cycle();
        chk("post_rst_busy", {31'd0, busy}, 32'd1);
        wait_idle(100);
        repeat (2) cycle();
        chk("post_rst_frames", {28'd0, frames_done}, 32'd1);
        chk("post_rst_bd", bd_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
